qsys_led_pio_blink: RTL and testbench
=====================================

Name: qsys_led_pio_blink

Overview:
- Parametrised Avalon-MM output PIO for board LEDs; successor to the fixed 16-bit LED port.
- Adds configurable width, atomic set/clear registers, per-bit blink enable and a programmable blink timebase.
- Sits on the Qsys system bus as a zero-wait-state slave; out_port drives the LED pins directly.

Parameters:
- WIDTH, 16, number of output bits (1..32).
- PRESC_W, 24, width of the blink half-period counter/register (1..32).
- RESET_DATA, 0, reset value of the DATA register (WIDTH bits).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address, zero wait states.
- out_port  out  WIDTH  LED drive.

Behaviour:
- Reset is reset_n, asynchronous, active-low; clock is clk. Reset values:
  - DATA=RESET_DATA; BLINK_EN=0; PERIOD=0; cnt=0; phase=0.
  - out_port=RESET_DATA; readdata follows the address decode.
- Register map (word addresses). All unused upper readdata bits read 0:
  - 0 DATA: R/W, writedata[WIDTH-1:0].
  - 1 BLINK_EN: R/W, per-bit blink enable.
  - 2 PERIOD: R/W, writedata[PRESC_W-1:0], blink half-period in clk cycles.
  - 3 reserved: reads 0, writes ignored.
  - 4 OUTSET: write only. DATA <= DATA | wd. Reads 0.
  - 5 OUTCLEAR: write only. DATA <= DATA & ~wd. Reads 0.
  - 6 STATUS: read returns {31'b0, phase}. Any write restarts the timebase (cnt<=0, phase<=0).
  - 7 reserved: reads 0, writes ignored.
- Write timing: a write is captured on the clk edge where it is sampled. The new register value and out_port are visible immediately after that edge (latency 1 edge).
- Timebase, evaluated every clk edge, first matching rule applies:
  - Write to PERIOD or STATUS this cycle: cnt<=0, phase<=0. For PERIOD, the new value is loaded too.
  - PERIOD==0: cnt<=0, phase<=0 (blink frozen).
  - cnt==PERIOD-1: cnt<=0, phase<=~phase.
  - Otherwise: cnt<=cnt+1.
  - Result: phase toggles every PERIOD cycles, so full blink period = 2*PERIOD cycles.
- Reducing PERIOD below the current cnt is covered by the PERIOD-write restart rule, so there is no wrap-around stall.
- Output: out_port[i] = DATA[i] & (~BLINK_EN[i] | phase).
  - A blinking bit is off in phase 0 and on in phase 1.
  - With PERIOD=0, enabled blink bits stay off.
- Read mux is purely combinational, like the DATA readback; chipselect is not required for readdata.
- Reset mid-operation immediately forces all state to reset values, independent of clk.
- WIDTH<32: writedata bits above WIDTH are ignored and read back as 0.

Decomposition:
- Shared package qsys_led_pkg holds:
  - register address constants ADDR_DATA=0, ADDR_BLINK=1, ADDR_PERIOD=2, ADDR_SET=4, ADDR_CLR=5, ADDR_STATUS=6;
  - MAX_WIDTH=32.
- One natural sub-module: qsys_led_blink_timer (PERIOD register, cnt, phase, restart input). The top level keeps the register file, set/clear logic and read mux.

Test Plan:
- Reset: assert reset_n=0 with RESET_DATA=16'h00A5 -> out_port=16'h00A5; reads of 1, 2 and 6 all return 0.
- Set/clear:
  - Write DATA=16'h00F0 -> out_port=16'h00F0.
  - Then OUTSET wd=16'h000F -> 16'h00FF, and reading addr 4 returns 0.
  - Then OUTCLEAR wd=16'h0081 -> 16'h007E.
- Blink: DATA=16'hFFFF, BLINK_EN=16'h0001, PERIOD=4.
  - out_port[0] is 0 for 4 cycles, then 1 for 4 cycles, repeating.
  - Bits 15:1 stay 1 throughout; STATUS bit0 tracks out_port[0].
- PERIOD change mid-count: with cnt=3 and PERIOD=10, write PERIOD=2 -> phase=0 and cnt=0 on the next edge, then a toggle after 2 cycles with no stall. Writing PERIOD=0 -> out_port[0] stays 0 indefinitely.
- Width masking: WIDTH=8, write DATA=32'hFFFF_FF5A -> out_port=8'h5A, read addr 0 returns 32'h0000_005A.
- Async reset mid-blink: drop reset_n between clk edges while phase=1 -> out_port returns to RESET_DATA, STATUS reads 0, and BLINK_EN reads 0 before the next clk edge.

Source files
------------

// File: rtl/qsys_led_pkg.sv
// Shared constants for the blinking LED PIO: register word addresses and bus width.
package qsys_led_pkg;

    localparam int MAX_WIDTH = 32;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_BLINK  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_SET    = 3'd4;
    localparam logic [2:0] ADDR_CLR    = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

endpackage

// File: rtl/qsys_led_pio_blink_if.sv
// Avalon-MM slave bus bundle for the LED PIO (zero wait states, no byte enables).
interface qsys_led_pio_blink_if;
    import qsys_led_pkg::*;

    logic [2:0]           address;
    logic                 chipselect;
    logic                 write_n;
    logic [MAX_WIDTH-1:0] writedata;
    logic [MAX_WIDTH-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/qsys_led_blink_timer.sv
// Blink timebase: holds the half-period register and toggles phase every PERIOD cycles.
module qsys_led_blink_timer #(
    parameter int PRESC_W = 24
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_period,
    input  logic               restart,
    input  logic [PRESC_W-1:0] period_in,
    output logic [PRESC_W-1:0] period,
    output logic               phase
);

    logic [PRESC_W-1:0] cnt;

    // Any PERIOD or STATUS write restarts the count, so a shorter period never strands cnt above it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period <= '0;
            cnt    <= '0;
            phase  <= 1'b0;
        end else begin
            if (load_period) begin
                period <= period_in;
            end
            if (load_period || restart) begin
                cnt   <= '0;
                phase <= 1'b0;
            end else if (period == '0) begin
                cnt   <= '0;
                phase <= 1'b0;
            end else if (cnt == period - PRESC_W'(1)) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + PRESC_W'(1);
            end
        end
    end

endmodule

// File: rtl/qsys_led_pio_blink.sv
// Avalon-MM LED output port with atomic set/clear and per-bit blinking.
module qsys_led_pio_blink
    import qsys_led_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter int               PRESC_W    = 24,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    qsys_led_pio_blink_if.slave  bus,
    output logic [WIDTH-1:0]     out_port
);

    logic [WIDTH-1:0]     data;
    logic [WIDTH-1:0]     blink_en;
    logic [PRESC_W-1:0]   period;
    logic                 phase;
    logic                 wr_en;
    logic [WIDTH-1:0]     wd;
    logic [MAX_WIDTH-1:0] rdata;
    logic                 unused_wd;

    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign wd        = bus.writedata[WIDTH-1:0];
    assign unused_wd = ^bus.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= RESET_DATA;
        end else if (wr_en) begin
            case (bus.address)
                ADDR_DATA: data <= wd;
                ADDR_SET:  data <= data | wd;
                ADDR_CLR:  data <= data & ~wd;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_en <= '0;
        end else if (wr_en && bus.address == ADDR_BLINK) begin
            blink_en <= wd;
        end
    end

    qsys_led_blink_timer #(
        .PRESC_W(PRESC_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_period(wr_en && bus.address == ADDR_PERIOD),
        .restart    (wr_en && bus.address == ADDR_STATUS),
        .period_in  (bus.writedata[PRESC_W-1:0]),
        .period     (period),
        .phase      (phase)
    );

    // Readback ignores chipselect so the bus sees stable data as soon as the address settles.
    always_comb begin
        rdata = '0;
        case (bus.address)
            ADDR_DATA:   rdata[WIDTH-1:0]   = data;
            ADDR_BLINK:  rdata[WIDTH-1:0]   = blink_en;
            ADDR_PERIOD: rdata[PRESC_W-1:0] = period;
            ADDR_STATUS: rdata[0]           = phase;
            default:     rdata = '0;
        endcase
    end

    assign bus.readdata = rdata;
    assign out_port     = data & (~blink_en | {WIDTH{phase}});

endmodule

// File: tb/tb_qsys_led_pio_blink.sv
// Drives a 16-bit and an 8-bit LED PIO with identical bus traffic and checks both against a cycle-count model.
module tb_qsys_led_pio_blink;
    import qsys_led_pkg::*;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic [2:0]  drv_addr = 3'd0;
    logic        drv_cs   = 1'b0;
    logic        drv_wn   = 1'b1;
    logic [31:0] drv_wd   = 32'd0;
    logic [15:0] out16;
    logic [7:0]  out8;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] m_data16;
    logic [15:0] m_blink16;
    logic [7:0]  m_data8;
    logic [7:0]  m_blink8;
    logic [23:0] m_period;
    longint      m_elapsed;

    always #5 clk = ~clk;

    qsys_led_pio_blink_if bus16();
    qsys_led_pio_blink_if bus8();

    assign bus16.address    = drv_addr;
    assign bus16.chipselect = drv_cs;
    assign bus16.write_n    = drv_wn;
    assign bus16.writedata  = drv_wd;
    assign bus8.address     = drv_addr;
    assign bus8.chipselect  = drv_cs;
    assign bus8.write_n     = drv_wn;
    assign bus8.writedata   = drv_wd;

    qsys_led_pio_blink #(
        .WIDTH(16), .PRESC_W(24), .RESET_DATA(16'h00A5)
    ) dut16 (
        .clk(clk), .reset_n(reset_n), .bus(bus16), .out_port(out16)
    );

    qsys_led_pio_blink #(
        .WIDTH(8), .PRESC_W(24), .RESET_DATA(8'h00)
    ) dut8 (
        .clk(clk), .reset_n(reset_n), .bus(bus8), .out_port(out8)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Phase is derived from edges elapsed since the last restart rather than a running counter.
    function automatic logic m_phase();
        if (m_period == 24'd0) return 1'b0;
        return ((m_elapsed / longint'(m_period)) % 2) == 1;
    endfunction

    function automatic logic [15:0] m_out16();
        return m_data16 & (~m_blink16 | {16{m_phase()}});
    endfunction

    function automatic logic [7:0] m_out8();
        return m_data8 & (~m_blink8 | {8{m_phase()}});
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] addr, input bit narrow);
        case (addr)
            3'd0:    return narrow ? {24'd0, m_data8}  : {16'd0, m_data16};
            3'd1:    return narrow ? {24'd0, m_blink8} : {16'd0, m_blink16};
            3'd2:    return {8'd0, m_period};
            3'd6:    return {31'd0, m_phase()};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_data16  = 16'h00A5;
        m_blink16 = 16'h0000;
        m_data8   = 8'h00;
        m_blink8  = 8'h00;
        m_period  = 24'd0;
        m_elapsed = 0;
    endtask

    task automatic model_edge();
        bit restart;
        restart = 1'b0;
        if (drv_cs && !drv_wn) begin
            case (drv_addr)
                ADDR_DATA:   begin m_data16 = drv_wd[15:0]; m_data8 = drv_wd[7:0]; end
                ADDR_BLINK:  begin m_blink16 = drv_wd[15:0]; m_blink8 = drv_wd[7:0]; end
                ADDR_PERIOD: begin m_period = drv_wd[23:0]; restart = 1'b1; end
                ADDR_SET:    begin m_data16 |= drv_wd[15:0]; m_data8 |= drv_wd[7:0]; end
                ADDR_CLR:    begin m_data16 &= ~drv_wd[15:0]; m_data8 &= ~drv_wd[7:0]; end
                ADDR_STATUS: restart = 1'b1;
                default:     ;
            endcase
        end
        m_elapsed = restart ? 0 : m_elapsed + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic driveCycle(input logic cs, input logic wn, input logic [2:0] addr, input logic [31:0] wd);
        drv_cs   = cs;
        drv_wn   = wn;
        drv_addr = addr;
        drv_wd   = wd;
        tick();
        drv_cs = 1'b0;
        drv_wn = 1'b1;
    endtask

    task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] wd);
        driveCycle(1'b1, 1'b0, addr, wd);
    endtask

    task automatic checkPorts(input string tag);
        checkOutput({tag, "_out16"}, {16'd0, out16}, {16'd0, m_out16()});
        checkOutput({tag, "_out8"}, {24'd0, out8}, {24'd0, m_out8()});
    endtask

    task automatic checkRead(input string tag, input logic [2:0] addr);
        drv_addr = addr;
        #1;
        checkOutput({tag, "_rd16"}, bus16.readdata, m_read(addr, 1'b0));
        checkOutput({tag, "_rd8"}, bus8.readdata, m_read(addr, 1'b1));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0]  r_addr;
        logic [31:0] r_wd;
        model_reset();
        repeat (2) @(negedge clk);
        checkOutput("reset_out16_const", {16'd0, out16}, 32'h0000_00A5);
        checkPorts("reset");
        checkRead("reset_blink", 3'd1);
        checkRead("reset_period", 3'd2);
        checkRead("reset_status", 3'd6);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        applyStimulus(ADDR_DATA, 32'h0000_00F0);
        checkOutput("data_write", {16'd0, out16}, 32'h0000_00F0);
        applyStimulus(ADDR_SET, 32'h0000_000F);
        checkOutput("outset", {16'd0, out16}, 32'h0000_00FF);
        checkRead("outset_readback", 3'd4);
        checkOutput("outset_reads_zero", bus16.readdata, 32'd0);
        applyStimulus(ADDR_CLR, 32'h0000_0081);
        checkOutput("outclear", {16'd0, out16}, 32'h0000_007E);
        checkPorts("setclr");

        applyStimulus(ADDR_DATA, 32'h0000_FFFF);
        applyStimulus(ADDR_BLINK, 32'h0000_0001);
        applyStimulus(ADDR_PERIOD, 32'd4);
        for (int k = 0; k < 16; k++) begin
            checkOutput("blink_bit0", {31'd0, out16[0]}, {31'd0, ((k / 4) % 2) == 1});
            checkOutput("blink_upper", {17'd0, out16[15:1]}, 32'h0000_7FFF);
            checkPorts("blink");
            checkRead("blink_status", 3'd6);
            tick();
        end

        applyStimulus(ADDR_PERIOD, 32'd10);
        repeat (3) tick();
        applyStimulus(ADDR_PERIOD, 32'd2);
        for (int k = 0; k < 6; k++) begin
            checkOutput("shrink_bit0", {31'd0, out16[0]}, {31'd0, ((k / 2) % 2) == 1});
            checkRead("shrink_status", 3'd6);
            tick();
        end
        applyStimulus(ADDR_PERIOD, 32'd0);
        for (int k = 0; k < 12; k++) begin
            checkOutput("frozen_bit0", {31'd0, out16[0]}, 32'd0);
            tick();
        end

        applyStimulus(ADDR_DATA, 32'hFFFF_FF5A);
        checkOutput("mask_out8", {24'd0, out8}, 32'h0000_005A);
        checkRead("mask", 3'd0);
        checkOutput("mask_rd8", bus8.readdata, 32'h0000_005A);

        for (int i = 0; i < 300; i++) begin
            r_addr = 3'($urandom_range(0, 7));
            r_wd   = $urandom;
            if (r_addr == ADDR_PERIOD) r_wd = $urandom_range(0, 5);
            driveCycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, r_addr, r_wd);
            checkPorts("rand");
            checkRead("rand", 3'($urandom_range(0, 7)));
        end

        applyStimulus(ADDR_DATA, 32'h0000_FFFF);
        applyStimulus(ADDR_BLINK, 32'h0000_0001);
        applyStimulus(ADDR_PERIOD, 32'd3);
        repeat (4) tick();
        checkRead("prereset_status", 3'd6);
        @(posedge clk);
        model_edge();
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        checkOutput("async_out16", {16'd0, out16}, 32'h0000_00A5);
        checkPorts("async");
        drv_addr = 3'd6;
        #1 checkOutput("async_status", bus16.readdata, 32'd0);
        drv_addr = 3'd1;
        #1 checkOutput("async_blink", bus16.readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) tick();
        checkPorts("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
